// File: rtl/loop_seq_ctrl.sv
// Nested-loop sequencer: walks k = inner_base..0 for each i = 0..outer_lim over a
// captured 16-word buffer, accumulating i and buf[k], guarded by an egg-timer watchdog.
module loop_seq_ctrl #(
  parameter logic [6:0] TIMEOUT_INIT = 7'd127
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   outer_lim,
  input  logic [3:0]   inner_base,
  input  logic [511:0] data_in,
  output logic [3:0]   sel_idx,
  output logic [31:0]  sel_word,
  output logic         sel_valid,
  output logic [31:0]  acc,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [6:0]   egg_timer
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    OUTER,
    INNER,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [31:0] word_q [16];
  logic [3:0]  outer_lim_q;
  logic [3:0]  inner_base_q;
  logic [3:0]  i_q;
  logic [3:0]  k_q;
  logic [31:0] acc_q;
  logic [31:0] sel_word_q;
  logic        timeout_q;
  logic [6:0]  egg_q;

  // Per-edge strobes decoded from the current state.
  logic capture;
  logic tick;
  logic abort;
  logic do_outer;
  logic do_inner;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    tick      = 1'b0;
    abort     = 1'b0;
    do_outer  = 1'b0;
    do_inner  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        tick      = 1'b1;
        state_nxt = OUTER;
      end
      OUTER: begin
        if (egg_q == 7'd0) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          tick      = 1'b1;
          do_outer  = 1'b1;
          state_nxt = INNER;
        end
      end
      INNER: begin
        if (egg_q == 7'd0) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          tick     = 1'b1;
          do_inner = 1'b1;
          if (k_q == 4'd0) state_nxt = (i_q == outer_lim_q) ? FINISH : OUTER;
          else             state_nxt = INNER;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // k (and the captured sel_word) only change on edges that land in INNER,
  // so they hold their last values everywhere else.
  // NOTE: the word buffer is reset explicitly; it is small and must read as
  // zero after reset, so it is kept as flops rather than a RAM.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 16; j++) word_q[j] <= '0;
      outer_lim_q  <= '0;
      inner_base_q <= '0;
      i_q          <= '0;
      k_q          <= '0;
      acc_q        <= '0;
      sel_word_q   <= '0;
      timeout_q    <= 1'b0;
      egg_q        <= '0;
    end else begin
      if (capture) begin
        for (int j = 0; j < 16; j++) word_q[j] <= data_in[32*j +: 32];
        outer_lim_q  <= outer_lim;
        inner_base_q <= inner_base;
        i_q          <= '0;
        acc_q        <= '0;
        timeout_q    <= 1'b0;
        egg_q        <= TIMEOUT_INIT;
      end
      if (tick)  egg_q     <= egg_q - 7'd1;
      if (abort) timeout_q <= 1'b1;
      if (do_outer) begin
        acc_q      <= acc_q + {28'd0, i_q};
        k_q        <= inner_base_q;
        sel_word_q <= word_q[inner_base_q];
      end
      if (do_inner) begin
        acc_q <= acc_q + word_q[k_q];
        if (k_q == 4'd0) begin
          if (i_q != outer_lim_q) i_q <= i_q + 4'd1;
        end else begin
          k_q        <= k_q - 4'd1;
          sel_word_q <= word_q[k_q - 4'd1];
        end
      end
    end
  end

  assign sel_idx   = k_q;
  assign sel_word  = sel_word_q;
  assign sel_valid = (state == INNER);
  assign acc       = acc_q;
  assign busy      = (state == LOAD) || (state == OUTER) || (state == INNER);
  assign done      = (state == FINISH);
  assign timeout   = timeout_q;
  assign egg_timer = egg_q;

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Directed bench for loop_seq_ctrl: per-edge walk of a reference sequence, wrap,
// watchdog abort, input isolation while busy, and mid-sequence reset.
module tb_loop_seq_ctrl;

  logic         sysclk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   outer_lim;
  logic [3:0]   inner_base;
  logic [511:0] data_in;
  logic [3:0]   sel_idx;
  logic [31:0]  sel_word;
  logic         sel_valid;
  logic [31:0]  acc;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [6:0]   egg_timer;

  int tests = 0;
  int fails = 0;

  loop_seq_ctrl #(.TIMEOUT_INIT(7'd127)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .start     (start),
    .outer_lim (outer_lim),
    .inner_base(inner_base),
    .data_in   (data_in),
    .sel_idx   (sel_idx),
    .sel_word  (sel_word),
    .sel_valid (sel_valid),
    .acc       (acc),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .egg_timer (egg_timer)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_ref_words();
    for (int j = 0; j < 16; j++) data_in[32*j +: 32] = 32'(j + 1);
  endtask

  // Drives start across one edge (edge 0) and returns the edge index at which done
  // was seen, or -1 if none within the budget.
  task automatic run_seq(input logic [3:0] ol, input logic [3:0] ib, output int done_edge);
    outer_lim  = ol;
    inner_base = ib;
    start      = 1'b1;
    tick_edge();
    start     = 1'b0;
    done_edge = -1;
    for (int n = 1; n <= 300 && done_edge < 0; n++) begin
      tick_edge();
      if (done) done_edge = n;
    end
  endtask

  // Expected values after edges 1..10 of the reference sequence (words j+1, ol=1, ib=2).
  int exp_idx   [10] = '{0, 2, 1, 0, 0, 2, 1, 0, 0, 0};
  int exp_word  [10] = '{0, 3, 2, 1, 1, 3, 2, 1, 1, 1};
  int exp_valid [10] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
  int exp_acc   [10] = '{0, 0, 3, 5, 6, 7, 10, 12, 13, 13};
  int exp_busy  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int exp_done  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  int exp_egg   [10] = '{126, 125, 124, 123, 122, 121, 120, 119, 118, 118};

  initial begin
    int    de;
    int    to_edge;
    int    saw_done;
    int    egg_at_127;
    int    busy_at_127;
    string tag;

    reset      = 1'b1;
    start      = 1'b0;
    outer_lim  = '0;
    inner_base = '0;
    data_in    = '0;

    // Reset values before any clock edge.
    #2;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_to",    32'(timeout), 32'd0);
    check("rst_valid", 32'(sel_valid), 32'd0);
    check("rst_idx",   32'(sel_idx), 32'd0);
    check("rst_word",  sel_word, 32'd0);
    check("rst_acc",   acc, 32'd0);
    check("rst_egg",   32'(egg_timer), 32'd0);

    // start while in reset must be ignored.
    start = 1'b1;
    tick_edge();
    check("rst_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    tick_edge();
    reset = 1'b0;
    tick_edge();

    // Reference sequence, checked at every edge.
    set_ref_words();
    outer_lim  = 4'd1;
    inner_base = 4'd2;
    start      = 1'b1;
    tick_edge();
    start = 1'b0;
    check("ref_e0_busy", 32'(busy), 32'd1);
    check("ref_e0_egg",  32'(egg_timer), 32'd127);
    for (int n = 1; n <= 10; n++) begin
      tick_edge();
      tag = $sformatf("ref_e%0d", n);
      check({tag, "_idx"},   32'(sel_idx),   32'(exp_idx[n-1]));
      check({tag, "_word"},  sel_word,       32'(exp_word[n-1]));
      check({tag, "_valid"}, 32'(sel_valid), 32'(exp_valid[n-1]));
      check({tag, "_acc"},   acc,            32'(exp_acc[n-1]));
      check({tag, "_busy"},  32'(busy),      32'(exp_busy[n-1]));
      check({tag, "_done"},  32'(done),      32'(exp_done[n-1]));
      check({tag, "_egg"},   32'(egg_timer), 32'(exp_egg[n-1]));
    end

    // Single-iteration wrap path and a two-iteration wrap.
    data_in = '0;
    data_in[31:0] = 32'hFFFF_FFFF;
    run_seq(4'd0, 4'd0, de);
    check("wrap0_done_edge", 32'(de), 32'd3);
    check("wrap0_acc", acc, 32'hFFFF_FFFF);
    tick_edge();
    run_seq(4'd1, 4'd0, de);
    check("wrap1_done_edge", 32'(de), 32'd5);
    check("wrap1_acc", acc, 32'hFFFF_FFFF);
    tick_edge();

    // Watchdog abort: FINISH would be at edge 273, so abort lands at edge 128.
    set_ref_words();
    outer_lim  = 4'd15;
    inner_base = 4'd15;
    start      = 1'b1;
    tick_edge();
    start       = 1'b0;
    to_edge     = -1;
    saw_done    = 0;
    egg_at_127  = -1;
    busy_at_127 = -1;
    for (int n = 1; n <= 140; n++) begin
      tick_edge();
      if (done) saw_done = 1;
      if (timeout && to_edge < 0) to_edge = n;
      if (n == 127) begin
        egg_at_127  = int'(egg_timer);
        busy_at_127 = int'(busy);
      end
    end
    check("to_egg_127",  32'(egg_at_127), 32'd0);
    check("to_busy_127", 32'(busy_at_127), 32'd1);
    check("to_edge",     32'(to_edge), 32'd128);
    check("to_no_done",  32'(saw_done), 32'd0);
    check("to_flag",     32'(timeout), 32'd1);
    check("to_busy",     32'(busy), 32'd0);
    check("to_egg",      32'(egg_timer), 32'd0);

    // Next start clears the sticky flag.
    outer_lim  = 4'd0;
    inner_base = 4'd0;
    start      = 1'b1;
    tick_edge();
    start = 1'b0;
    check("to_clear", 32'(timeout), 32'd0);
    for (int n = 0; n < 4; n++) tick_edge();

    // Inputs and start toggled while busy have no effect.
    set_ref_words();
    outer_lim  = 4'd1;
    inner_base = 4'd2;
    start      = 1'b1;
    tick_edge();
    de = -1;
    for (int n = 1; n <= 40 && de < 0; n++) begin
      if (n < 7) begin
        start      = n[0];
        outer_lim  = 4'(n + 3);
        inner_base = 4'(n);
        data_in    = {16{32'h1234_5678 + 32'(n)}};
      end else begin
        start = 1'b0;
      end
      tick_edge();
      if (done) de = n;
    end
    check("iso_done_edge", 32'(de), 32'd9);
    check("iso_acc", acc, 32'd13);

    // Reset at edge 5 of the reference sequence, then a clean rerun.
    tick_edge();
    set_ref_words();
    outer_lim  = 4'd1;
    inner_base = 4'd2;
    start      = 1'b1;
    tick_edge();
    start = 1'b0;
    for (int n = 1; n <= 4; n++) tick_edge();
    @(posedge sysclk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_done",  32'(done), 32'd0);
    check("mid_rst_valid", 32'(sel_valid), 32'd0);
    check("mid_rst_idx",   32'(sel_idx), 32'd0);
    check("mid_rst_word",  sel_word, 32'd0);
    check("mid_rst_acc",   acc, 32'd0);
    check("mid_rst_egg",   32'(egg_timer), 32'd0);
    saw_done = 0;
    for (int n = 0; n < 3; n++) begin
      tick_edge();
      if (done) saw_done = 1;
    end
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    reset = 1'b0;
    tick_edge();
    run_seq(4'd1, 4'd2, de);
    check("rerun_done_edge", 32'(de), 32'd9);
    check("rerun_acc", acc, 32'd13);
    tick_edge();
    check("rerun_idle", 32'(busy | done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
